// File: rtl/booth_nr_sequencer_if.sv
// rtl/booth_nr_sequencer_if.sv - command, result and step-stage bundle for booth_nr_sequencer.
// slave is the sequencer side; master is the requester plus the combinational step stage.
interface booth_nr_sequencer_if #(
  parameter int N = 4
);
  logic           start;
  logic           op;
  logic [N-1:0]   data_x;
  logic [N-1:0]   data_y;
  logic           busy;
  logic           done;
  logic [N-1:0]   result_hi;
  logic [N-1:0]   result_lo;
  logic           div_by_zero;
  logic           range_err;
  logic [N-1:0]   a_plus_m;
  logic [N-1:0]   a_minus_m;
  logic [N-1:0]   a;
  logic [N:0]     q;
  logic           op_o;
  logic           a_sign;
  logic           q0;
  logic           q1;
  logic [2*N:0]   aq_in;

  modport slave (
    input  start, op, data_x, data_y, aq_in,
    output busy, done, result_hi, result_lo, div_by_zero, range_err,
           a_plus_m, a_minus_m, a, q, op_o, a_sign, q0, q1
  );

  modport master (
    output start, op, data_x, data_y, aq_in,
    input  busy, done, result_hi, result_lo, div_by_zero, range_err,
           a_plus_m, a_minus_m, a, q, op_o, a_sign, q0, q1
  );
endinterface

// File: rtl/booth_nr_sequencer.sv
// rtl/booth_nr_sequencer.sv - Booth multiply / non-restoring divide sequencer feeding the step stage.
// Optional divide operand range check is built in when SEQ_RANGE_CHECK_EN is defined.
module booth_nr_sequencer #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_nr_sequencer_if.slave   bus
);
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] C_MUL_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_DIV_LAST = CW'(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_q;
  logic          r_qm1;
  logic [N-1:0]  r_m;
  logic          r_op;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_rem_snap;
  logic [N-1:0]  r_result_hi;
  logic [N-1:0]  r_result_lo;
  logic          r_done;
  logic          r_busy;
  logic          r_div_by_zero;
`ifdef SEQ_RANGE_CHECK_EN
  logic          r_range_err;
`endif

  logic [N-1:0]  w_ash;
  logic [N-1:0]  w_a_base;
  logic [N-1:0]  w_aq_a;
  logic [N-1:0]  w_aq_q;
  logic [N-1:0]  w_snap;
  logic          w_last;
  logic          w_snap_now;

  // Division works on the left-shifted partial remainder; add/sub choice uses the pre-shift sign.
  assign w_ash      = {r_a[N-2:0], r_q[N-1]};
  assign w_a_base   = r_op ? w_ash : r_a;
  assign w_aq_a     = bus.aq_in[2*N:N+1];
  assign w_aq_q     = bus.aq_in[N:1];
  // The Nth division step leaves the true remainder, restored here if it went negative.
  assign w_snap     = w_aq_a + (w_aq_a[N-1] ? r_m : {N{1'b0}});
  assign w_last     = r_op ? (r_cnt == C_DIV_LAST) : (r_cnt == C_MUL_LAST);
  assign w_snap_now = r_op && (r_cnt == C_MUL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_a           <= '0;
      r_q           <= '0;
      r_qm1         <= 1'b0;
      r_m           <= '0;
      r_op          <= 1'b0;
      r_cnt         <= '0;
      r_rem_snap    <= '0;
      r_result_hi   <= '0;
      r_result_lo   <= '0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_div_by_zero <= 1'b0;
`ifdef SEQ_RANGE_CHECK_EN
      r_range_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a           <= '0;
            r_q           <= bus.data_x;
            r_qm1         <= 1'b0;
            r_m           <= bus.data_y;
            r_op          <= bus.op;
            r_cnt         <= '0;
            r_div_by_zero <= 1'b0;
`ifdef SEQ_RANGE_CHECK_EN
            r_range_err   <= 1'b0;
            if (bus.op && (bus.data_x[N-1] || bus.data_y[N-1])) begin
              r_range_err <= 1'b1;
              r_result_hi <= '0;
              r_result_lo <= '0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end else
`endif
            if (bus.op && (bus.data_y == '0)) begin
              r_result_lo   <= '1;
              r_result_hi   <= bus.data_x;
              r_div_by_zero <= 1'b1;
              r_done        <= 1'b1;
              r_state       <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_a   <= w_aq_a;
          r_q   <= w_aq_q;
          r_qm1 <= bus.aq_in[0];
          r_cnt <= r_cnt + 1'b1;
          if (w_snap_now) begin
            r_rem_snap <= w_snap;
          end
          if (w_last) begin
            r_result_hi <= r_op ? r_rem_snap : w_aq_a;
            r_result_lo <= w_aq_q;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result_hi   = r_result_hi;
  assign bus.result_lo   = r_result_lo;
  assign bus.div_by_zero = r_div_by_zero;
`ifdef SEQ_RANGE_CHECK_EN
  assign bus.range_err   = r_range_err;
`else
  assign bus.range_err   = 1'b0;
`endif
  assign bus.a           = w_a_base;
  assign bus.a_plus_m    = w_a_base + r_m;
  assign bus.a_minus_m   = w_a_base - r_m;
  assign bus.q           = {r_q, (r_op ? 1'b0 : r_qm1)};
  assign bus.op_o        = r_op;
  assign bus.a_sign      = r_a[N-1];
  assign bus.q0          = r_qm1;
  assign bus.q1          = r_q[0];

endmodule

// File: tb/tb_booth_nr_sequencer.sv
// tb/tb_booth_nr_sequencer.sv - directed bench with a behavioural step stage closing the loop.
module tb_booth_nr_sequencer;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_nr_sequencer_if #(.N(N)) bus ();
  booth_nr_sequencer #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Step stage: Booth add/sub plus arithmetic shift using the true (N+1)-bit sign,
  // or non-restoring step inserting the previous step's quotient bit.
  logic [N:0]   t_ext;
  logic [N-1:0] t_sum;
  always_comb begin
    t_ext     = {bus.a[N-1], bus.a};
    t_sum     = bus.a;
    bus.aq_in = '0;
    if (!bus.op_o) begin
      case ({bus.q1, bus.q0})
        2'b10: begin
          t_ext = {bus.a[N-1], bus.a} - {bus.data_y[N-1], bus.data_y};
          t_sum = bus.a_minus_m;
        end
        2'b01: begin
          t_ext = {bus.a[N-1], bus.a} + {bus.data_y[N-1], bus.data_y};
          t_sum = bus.a_plus_m;
        end
        default: ;
      endcase
      bus.aq_in = {t_ext[N], t_sum, bus.q[N:1]};
    end else begin
      t_sum     = bus.a_sign ? bus.a_plus_m : bus.a_minus_m;
      bus.aq_in = {t_sum, bus.q[N-1:1], ~bus.a_sign, 1'b0};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic op, input logic [N-1:0] x,
                        input logic [N-1:0] y, input int exp_done, input logic chk_res,
                        input logic [N-1:0] exp_hi, input logic [N-1:0] exp_lo,
                        input logic exp_dbz, input logic exp_rerr, input int pulse_at);
    int done_at  = -1;
    int busy_bad = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.data_x = x;
    bus.data_y = y;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.busy !== (c < exp_done)) busy_bad++;
      if (bus.done === 1'b1) begin
        done_at = c;
        break;
      end
      if (c == 1) check({tag, " op_o"}, 32'(bus.op_o), 32'(op));
      if (c == pulse_at) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    check({tag, " done_cycle"}, 32'(done_at), 32'(exp_done));
    check({tag, " busy_profile"}, 32'(busy_bad), 32'd0);
    if (chk_res) begin
      check({tag, " result_hi"}, 32'(bus.result_hi), 32'(exp_hi));
      check({tag, " result_lo"}, 32'(bus.result_lo), 32'(exp_lo));
      check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    end
    check({tag, " range_err"}, 32'(bus.range_err), 32'(exp_rerr));
    @(posedge clk);
    #1;
    check({tag, " post_done_idle"}, 32'({bus.done, bus.busy}), 32'd0);
  endtask

  initial begin
    int done_seen;
    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.data_x = '0;
    bus.data_y = '0;
    #12;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset results", 32'({bus.result_hi, bus.result_lo}), 32'd0);
    check("reset flags", 32'({bus.div_by_zero, bus.range_err}), 32'd0);
    check("reset operands", 32'({bus.a, bus.a_plus_m, bus.a_minus_m, bus.q}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul -2*3", 1'b0, 4'b1110, 4'b0011, 5, 1'b1, 4'hF, 4'hA, 1'b0, 1'b0, 0);
    run_op("div 7/2", 1'b1, 4'd7, 4'd2, 6, 1'b1, 4'd1, 4'd3, 1'b0, 1'b0, 0);
    run_op("div 5/0", 1'b1, 4'd5, 4'd0, 1, 1'b1, 4'd5, 4'hF, 1'b1, 1'b0, 0);
    run_op("div 5/7", 1'b1, 4'd5, 4'd7, 6, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 0);
    run_op("mul -8*-8", 1'b0, 4'b1000, 4'b1000, 5, 1'b1, 4'h4, 4'h0, 1'b0, 1'b0, 2);
    run_op("mul 7*-5", 1'b0, 4'd7, 4'b1011, 5, 1'b1, 4'hD, 4'hD, 1'b0, 1'b0, 0);

    // Abort a multiply in cycle 3 with reset.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = 1'b0;
    bus.data_x = 4'b1110;
    bus.data_y = 4'b0011;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort results", 32'({bus.result_hi, bus.result_lo}), 32'd0);
    check("abort operands", 32'({bus.a, bus.a_plus_m, bus.a_minus_m, bus.q, bus.op_o}), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_seen++;
    end
    check("abort no_done", 32'(done_seen), 32'd0);
    rst_n = 1'b1;
    run_op("mul after abort", 1'b0, 4'b1110, 4'b0011, 5, 1'b1, 4'hF, 4'hA, 1'b0, 1'b0, 0);

`ifdef SEQ_RANGE_CHECK_EN
    run_op("range 9/2", 1'b1, 4'h9, 4'd2, 1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 0);
`else
    run_op("range 9/2", 1'b1, 4'h9, 4'd2, 6, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/booth_nr_sequencer.md
Name: booth_nr_sequencer

Overview:
- Sequential controller and register file that sits directly upstream of the combinational `conditions` step stage in the P02 multiply/divide unit.
- Holds A, Q, Q-1 and M, and presents per-iteration operands to the step stage.
- Latches the step stage's 2N+1-bit aq result each cycle.
- Runs N Booth iterations for signed multiplication, or N+1 non-restoring iterations for division, then reports results with a done pulse.

Parameters:
- N, 4, operand width (N >= 3); iteration counter width $clog2(N+2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin operation; sampled only in IDLE
- op  input  1  0 = signed multiply, 1 = unsigned divide
- data_x  input  N  multiplier (op=0) / dividend (op=1)
- data_y  input  N  multiplicand / divisor (M)
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE
- result_hi  output  N  product[2N-1:N] / remainder
- result_lo  output  N  product[N-1:0] / quotient
- div_by_zero  output  1  set at done when op=1 and data_y=0
- range_err  output  1  see Optional Feature
- a_plus_m, a_minus_m, a  output  N  step-stage operands
- q  output  N+1  {Q, Q-1} in op=0; {Q, 1'b0} in op=1
- op_o  output  1  latched op, fed to step stage
- a_sign  output  1  A[N-1] (pre-shift sign)
- q0  output  1  Q-1
- q1  output  1  Q[0]
- aq_in  input  2N+1  step-stage result

Behaviour:
- Reset: state=IDLE; A, Q, Q-1, M, counter, rem_snap, result_hi, result_lo, done, busy, div_by_zero and range_err are all 0.
- Reset mid-operation aborts immediately. No done pulse is produced.
- IDLE:
  - On start=1: load A=0, Q=data_x, Q-1=0, M=data_y, op_r=op, cnt=0; go to RUN.
  - op=1 with data_y=0: go to DONE instead. Set result_lo=all ones, result_hi=data_x, div_by_zero=1.
- Operand drive:
  - op=0: a=A, a_plus_m=A+M, a_minus_m=A-M (mod 2^N).
  - op=1: Ash={A[N-2:0],Q[N-1]}; a=Ash, a_plus_m=Ash+M, a_minus_m=Ash-M.
- RUN, each cycle:
  - {A, Q, Q-1} <= aq_in, with A=aq_in[2N:N+1], Q=aq_in[N:1], Q-1=aq_in[0].
  - cnt <= cnt+1.
- Division snapshot: in op=1 on the cycle cnt=N-1, rem_snap <= aq_in[2N:N+1], plus M if that value is negative.
- Exit:
  - op=0: after N iterations, result_hi=A, result_lo=Q.
  - op=1: after N+1 iterations, result_lo=Q, result_hi=rem_snap.
  - Either mode then enters DONE.
- Latency from the start cycle (IDLE sampling edge = cycle 0):
  - done=1 in cycle N+1 for multiply, N+2 for divide, 1 for divide-by-zero.
- DONE: done=1 for one cycle, then IDLE. Results and flags hold until the next accepted start, which clears the flags.
- start during RUN or DONE is ignored.
- Division domain: data_x and data_y must have MSB=0. Otherwise results are unspecified unless range checking is built in.
- All arithmetic is modulo 2^N. No saturation.

Optional Feature:
- Macro SEQ_RANGE_CHECK_EN.
- Defined: in IDLE, an op=1 start with data_x[N-1] or data_y[N-1] set goes straight to DONE with range_err=1 and both results 0.
- Undefined: range_err is tied to 0 and no check is made.

Test Plan:
- N=4, op=0, data_x=4'b1110, data_y=4'b0011 (-2*3) -> done at cycle 5, {result_hi,result_lo}=8'hFA, busy cycles 1-4.
- N=4, op=1, data_x=7, data_y=2 -> done at cycle 6, result_lo=3, result_hi=1, div_by_zero=0.
- N=4, op=1, data_y=0, data_x=5 -> done at cycle 1, result_lo=4'hF, result_hi=5, div_by_zero=1.
- N=4, op=0, data_x=4'b1000, data_y=4'b1000 (-8*-8) -> product 8'h40; start pulsed again at cycle 2 is ignored.
- Reset asserted at cycle 3 of a multiply -> all outputs 0 asynchronously, no done; a new start after release gives correct results.
- With SEQ_RANGE_CHECK_EN: op=1, data_x=4'h9 -> done at cycle 1, range_err=1, results 0; without the macro range_err stays 0.
